// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: truth-table sweep and check of a single-output gate.
// Ports: clk, rst_n (async low), start (sweep request, honoured in IDLE),
//   dut_in (registered gate inputs, A = bit0), dut_out (gate output),
//   busy (sweep in progress), done (1-cycle report pulse),
//   pass / fail_mask (last sweep result, held until next accepted start).
// Option: define TT_SEQ_LOOP_EN for back-to-back sweeps after the first start.
module gate_tt_sequencer #(
    parameter int          N_IN     = 2,
    parameter logic [15:0] EXPECTED = 16'h000E,
    parameter int          SETTLE   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(1<<N_IN)-1:0]    fail_mask
);

    localparam int NV = 1 << N_IN;
    localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(NV - 1);
    localparam logic [3:0]    CNT_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [N_IN:0]   idx, idx_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [N_IN-1:0] din_nx;
    logic [NV-1:0]   mask_nx;
    logic            pass_nx;

    logic [N_IN:0]   idx_inc;
    logic [3:0]      sel;
    logic [NV-1:0]   hit;
    logic            miss;

    assign idx_inc = idx + (N_IN+1)'(1);
    assign sel     = 4'(idx[N_IN-1:0]);
    assign hit     = NV'(1) << idx[N_IN-1:0];
    // X on the gate output must register as a mismatch
    assign miss    = (dut_out !== EXPECTED[sel]);

    assign busy = (state == APPLY);
    assign done = (state == REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            dut_in    <= din_nx;
            fail_mask <= mask_nx;
            pass      <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        din_nx   = dut_in;
        mask_nx  = fail_mask;
        pass_nx  = pass;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = APPLY;
                    idx_nx   = '0;
                    din_nx   = '0;
                    cnt_nx   = CNT_INIT;
                    mask_nx  = '0;
                    pass_nx  = 1'b0;
                end
            end
            APPLY: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    mask_nx = fail_mask | (miss ? hit : '0);
                    if (idx == IDX_LAST) begin
                        state_nx = REPORT;
                        // result is settled on entry so it is valid alongside done
                        pass_nx  = ~|mask_nx;
                    end else begin
                        idx_nx = idx_inc;
                        din_nx = idx_inc[N_IN-1:0];
                        cnt_nx = CNT_INIT;
                    end
                end
            end
            REPORT: begin
                din_nx = '0;
`ifdef TT_SEQ_LOOP_EN
                state_nx = APPLY;
                idx_nx   = '0;
                cnt_nx   = CNT_INIT;
                mask_nx  = '0;
`else
                state_nx = IDLE;
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: directed bench for gate_tt_sequencer.
// Two instances: SETTLE=2 (main) and SETTLE=0 (short sweep).
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] dut_in, dut_in2;
    logic       dut_out, dut_out2;
    logic       busy, done, pass;
    logic       busy2, done2, pass2;
    logic [3:0] fail_mask, fail_mask2;
    int         gate_sel = 0;
    int         n_run = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic gate_f(input int g, input logic [1:0] v);
        case (g)
            0:       return v[0] | v[1];
            1:       return v[0] & v[1];
            default: return 1'b1;
        endcase
    endfunction

    assign dut_out  = gate_f(gate_sel, dut_in);
    assign dut_out2 = gate_f(gate_sel, dut_in2);

    gate_tt_sequencer #(.N_IN(2), .EXPECTED(16'h000E), .SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    gate_tt_sequencer #(.N_IN(2), .EXPECTED(16'h000E), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the chosen instance, then watch a fixed window.
    task automatic sweep(input int inst, input int s, input bit hold,
                         output int bcyc, output int dcnt, output int seq_err);
        bcyc = 0; dcnt = 0; seq_err = 0;
        if (inst == 0) start = 1'b1; else start2 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (inst == 0) begin
                if (busy) begin
                    bcyc++;
                    if (dut_in != 2'((bcyc - 1) / (s + 1))) seq_err++;
                end
                if (done) dcnt++;
                start = hold && busy;
            end else begin
                if (busy2) begin
                    bcyc++;
                    if (dut_in2 != 2'((bcyc - 1) / (s + 1))) seq_err++;
                end
                if (done2) dcnt++;
                start2 = 1'b0;
            end
        end
        start = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        int bc, dc, se;
        int last_done, gaps_bad, pass_bad;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_din", dut_in, 0);
        chk("rst_pass_mask", {pass, fail_mask}, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_din", dut_in, 0);

`ifndef TT_SEQ_LOOP_EN
        gate_sel = 0;
        sweep(0, 2, 1'b0, bc, dc, se);
        chk("or_busy_len", bc, 12);
        chk("or_done_cnt", dc, 1);
        chk("or_din_seq", se, 0);
        chk("or_pass", pass, 1);
        chk("or_mask", fail_mask, 4'b0000);
        chk("or_din_idle", dut_in, 0);

        gate_sel = 1;
        sweep(0, 2, 1'b0, bc, dc, se);
        chk("and_pass", pass, 0);
        chk("and_mask", fail_mask, 4'b0110);
        for (int k = 0; k < 20; k++) tick();
        chk("and_hold", {pass, fail_mask}, {1'b0, 4'b0110});

        gate_sel = 2;
        sweep(0, 2, 1'b0, bc, dc, se);
        chk("stuck_mask", fail_mask, 4'b0001);
        chk("stuck_pass", pass, 0);
        sweep(1, 0, 1'b0, bc, dc, se);
        chk("s0_busy_len", bc, 4);
        chk("s0_din_seq", se, 0);
        chk("s0_mask", fail_mask2, 4'b0001);
        chk("s0_done_cnt", dc, 1);

        gate_sel = 0;
        sweep(0, 2, 1'b1, bc, dc, se);
        chk("spam_busy_len", bc, 12);
        chk("spam_done_cnt", dc, 1);
        chk("spam_pass", pass, 1);
`else
        gate_sel = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        last_done = -1; gaps_bad = 0; pass_bad = 0; dc = 0;
        for (int k = 1; k <= 45; k++) begin
            if (done) begin
                if (last_done >= 0 && (k - 1 - last_done) != 13) gaps_bad++;
                if (!pass) pass_bad++;
                last_done = k - 1;
                dc++;
            end
            tick();
        end
        chk("loop_done_cnt", dc, 3);
        chk("loop_gap", gaps_bad, 0);
        chk("loop_pass", pass_bad, 0);
        chk("loop_busy", busy, 1);
`endif

        // Reset mid-sweep: outputs clear without waiting for a clock edge.
        gate_sel = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_din", dut_in, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy_done", {busy, done}, 0);
        chk("rst_mid_din", dut_in, 0);
        chk("rst_mid_res", {pass, fail_mask}, 0);
        tick();
        chk("rst_no_done", done, 0);
        rst_n = 1'b1;
        tick();
`ifndef TT_SEQ_LOOP_EN
        sweep(0, 2, 1'b0, bc, dc, se);
        chk("post_rst_len", bc, 12);
        chk("post_rst_pass", {pass, fail_mask}, {1'b1, 4'b0000});
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
